cpu_run_ctrl: RTL

- Run-control sequencer for the 4-bit CPU: owns the 16x8 program memory, drives the CPU's instruction input from the current PC, and issues one clock-enable pulse per instruction.
- Supports halt, free-run at a divided rate, single-step, restart and a one-address PC breakpoint.
- Program memory is writable from a host or loader only while the CPU is stopped.
- Sits between the board-level buttons/loader and the CPU core.

---
 rtl/cpu_ctrl_pkg.sv | 23 ++
 rtl/cpu_run_ctrl_if.sv | 34 +++
 rtl/cpu_run_ctrl_prog_mem.sv | 29 ++
 rtl/cpu_run_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared state encodings and bus widths for the CPU run-control block.
// Imported by the run-control interface, program memory and sequencer.
package cpu_ctrl_pkg;

  localparam int ADDR_W    = 4;
  localparam int INST_W    = 8;
  localparam int ST_W      = 3;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic [ST_W-1:0] {
    ST_RST  = 3'd0,
    ST_HALT = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_BRK  = 3'd4
  } run_state_e;

  // Program memory is only safe to modify while the CPU cannot fetch.
  function automatic logic can_write(input run_state_e s);
    return (s == ST_HALT) || (s == ST_BRK);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Command, breakpoint, loader and CPU-facing signals of the run controller.
// slave = the controller, master = buttons/loader/CPU side.
interface cpu_run_ctrl_if;
  import cpu_ctrl_pkg::*;

  logic              cmd_run;
  logic              cmd_halt;
  logic              cmd_step;
  logic              cmd_restart;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [INST_W-1:0] wr_data;
  logic [ADDR_W-1:0] pc;
  logic [INST_W-1:0] inst;
  logic              cpu_en;
  logic              cpu_reset;
  logic [ST_W-1:0]   state;
  logic              wr_err;

  modport master (
    output cmd_run, cmd_halt, cmd_step, cmd_restart,
    output bp_en, bp_addr, wr_en, wr_addr, wr_data, pc,
    input  inst, cpu_en, cpu_reset, state, wr_err
  );

  modport slave (
    input  cmd_run, cmd_halt, cmd_step, cmd_restart,
    input  bp_en, bp_addr, wr_en, wr_addr, wr_data, pc,
    output inst, cpu_en, cpu_reset, state, wr_err
  );

endinterface

// File: rtl/cpu_run_ctrl_prog_mem.sv
// 16x8 program store: synchronous write, combinational read, cleared on reset.
// Read data follows raddr in the same cycle; writes land on the clock edge.
module prog_mem
  import cpu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: halt/run/step/restart/breakpoint FSM gating the CPU clock enable.
// All outputs registered (one cycle after the sampled command) except inst, read from mem[pc].
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DIV          = 12000000,
  parameter int RESET_CYCLES = 4
) (
  input  logic         clk_cpu,
  input  logic         reset,
  cpu_run_ctrl_if.slave bus
);

  localparam int PRESC_W = $clog2(DIV);
  localparam int CNT_W   = $clog2(RESET_CYCLES + 1);
  localparam logic [PRESC_W-1:0] PRESC_FIRE = PRESC_W'(DIV - 2);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [CNT_W-1:0]   RST_LAST   = CNT_W'(RESET_CYCLES - 1);

  run_state_e         state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic               skip_q, skip_d;
  logic               cpu_en_q, cpu_en_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               wr_err_q;
  logic               leave_brk;
  logic               bp_hit;
  logic               wr_ok;

  assign bp_hit = bus.bp_en && (bus.pc == bus.bp_addr) && !skip_q;
  assign wr_ok  = bus.wr_en && can_write(state_q);

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    rst_cnt_d   = rst_cnt_q;
    skip_d      = skip_q;
    cpu_en_d    = 1'b0;
    cpu_reset_d = 1'b0;
    leave_brk   = 1'b0;

    if (bus.cmd_restart && (state_q != ST_RST)) begin
      state_d     = ST_RST;
      rst_cnt_d   = '0;
      cpu_reset_d = 1'b1;
    end else begin
      case (state_q)
        ST_RST: begin
          skip_d  = 1'b0;
          presc_d = '0;
          if (rst_cnt_q == RST_LAST) begin
            state_d = ST_HALT;
          end else begin
            rst_cnt_d   = rst_cnt_q + 1'b1;
            cpu_reset_d = 1'b1;
          end
        end
        ST_HALT, ST_BRK: begin
          // halt outranks step/run even though it leaves the state unchanged
          if (!bus.cmd_halt) begin
            if (bus.cmd_step) begin
              state_d   = ST_STEP;
              cpu_en_d  = 1'b1;
              leave_brk = (state_q == ST_BRK);
            end else if (bus.cmd_run) begin
              state_d   = ST_RUN;
              presc_d   = '0;
              leave_brk = (state_q == ST_BRK);
            end
          end
        end
        ST_RUN: begin
          if (bus.cmd_halt) begin
            state_d = ST_HALT;
          end else begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
            if (presc_q == PRESC_FIRE) begin
              if (bp_hit) begin
                state_d = ST_BRK;
              end else begin
                cpu_en_d = 1'b1;
              end
            end
          end
        end
        ST_STEP: state_d = ST_HALT;
        default: begin
          state_d     = ST_RST;
          rst_cnt_d   = '0;
          cpu_reset_d = 1'b1;
        end
      endcase

      // Leaving BRK arms the skip so the breakpointed instruction can execute once.
      if (leave_brk) begin
        skip_d = 1'b1;
      end else if (cpu_en_d) begin
        skip_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_q     <= ST_RST;
      presc_q     <= '0;
      rst_cnt_q   <= '0;
      skip_q      <= 1'b0;
      cpu_en_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      rst_cnt_q   <= rst_cnt_d;
      skip_q      <= skip_d;
      cpu_en_q    <= cpu_en_d;
      cpu_reset_q <= cpu_reset_d;
      wr_err_q    <= bus.wr_en && !can_write(state_q);
    end
  end

  prog_mem u_mem (
    .clk   (clk_cpu),
    .reset (reset),
    .we    (wr_ok),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (bus.pc),
    .rdata (bus.inst)
  );

  assign bus.cpu_en    = cpu_en_q;
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.state     = state_q;
  assign bus.wr_err    = wr_err_q;

endmodule
